cbus_arbiter: RTL and testbench

//  Shares the single core memory bus (cbus) between the I-side requester (icache refill)
//  and the D-side requester (dcache refill/writeback or uncached access).

---
 rtl/cbus_arbiter.sv | 98 +++++++++
 tb/tb_cbus_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cbus_arbiter.sv
// cbus_arbiter: shares the core memory bus between the I-side and D-side requesters,
// holding one grant per burst and flagging beat-count protocol errors.
module cbus_arbiter #(
    parameter int ROUND_ROBIN = 1,
    parameter int LEN_W       = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_req_valid,
    input  logic [31:0]      i_req_addr,
    input  logic [LEN_W-1:0] i_req_len,
    output logic             i_resp_ready,
    output logic             i_resp_last,
    output logic [31:0]      i_resp_data,
    input  logic             d_req_valid,
    input  logic             d_req_is_write,
    input  logic [31:0]      d_req_addr,
    input  logic [2:0]       d_req_size,
    input  logic [LEN_W-1:0] d_req_len,
    input  logic [3:0]       d_req_strobe,
    input  logic [31:0]      d_req_data,
    input  logic             d_uncached,
    output logic             d_resp_ready,
    output logic             d_resp_last,
    output logic [31:0]      d_resp_data,
    output logic             c_req_valid,
    output logic             c_req_is_write,
    output logic [31:0]      c_req_addr,
    output logic [2:0]       c_req_size,
    output logic [LEN_W-1:0] c_req_len,
    output logic [3:0]       c_req_strobe,
    output logic [31:0]      c_req_data,
    output logic             c_uncached,
    input  logic             c_resp_ready,
    input  logic             c_resp_last,
    input  logic [31:0]      c_resp_data,
    output logic             proto_err
);
    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

    state_t           state;
    logic             last_d;
    logic [LEN_W-1:0] beat;
    logic             gi, gd;
    logic [LEN_W-1:0] cur_len;

    assign gi      = (state == GNT_I);
    assign gd      = (state == GNT_D);
    assign cur_len = gd ? d_req_len : i_req_len;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            last_d    <= 1'b0;
            beat      <= '0;
            proto_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    beat <= '0;
                    if (d_req_valid && (!i_req_valid || ROUND_ROBIN == 0 || !last_d))
                        state <= GNT_D;
                    else if (i_req_valid)
                        state <= GNT_I;
                end
                GNT_I, GNT_D: begin
                    if (c_resp_ready) begin
                        beat <= beat + 1'b1;
                        // last must land exactly on beat==len, and nowhere else
                        if (c_resp_last != (beat == cur_len))
                            proto_err <= 1'b1;
                        if (c_resp_last) begin
                            state  <= IDLE;
                            last_d <= gd;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign c_req_valid    = gi | gd;
    assign c_req_is_write = gd & d_req_is_write;
    assign c_req_addr     = gd ? d_req_addr : gi ? i_req_addr : '0;
    assign c_req_size     = gd ? d_req_size : gi ? 3'b010 : 3'b000;
    assign c_req_len      = gd ? d_req_len : gi ? i_req_len : '0;
    assign c_req_strobe   = gd ? d_req_strobe : 4'h0;
    assign c_req_data     = gd ? d_req_data : '0;
    assign c_uncached     = gd & d_uncached;

    assign i_resp_ready = gi & c_resp_ready;
    assign i_resp_last  = gi & c_resp_last;
    assign i_resp_data  = gi ? c_resp_data : '0;
    assign d_resp_ready = gd & c_resp_ready;
    assign d_resp_last  = gd & c_resp_last;
    assign d_resp_data  = gd ? c_resp_data : '0;
endmodule

// File: tb/tb_cbus_arbiter.sv
// tb_cbus_arbiter: drives a round-robin and a fixed-priority arbiter with shared stimulus
// and compares both against a transaction-level model every cycle.
module tb_cbus_arbiter;
    logic        clk = 0, resetn = 1;
    logic        i_req_valid = 0;
    logic [31:0] i_req_addr = 0;
    logic [3:0]  i_req_len = 0;
    logic        d_req_valid = 0, d_req_is_write = 0, d_uncached = 0;
    logic [31:0] d_req_addr = 0, d_req_data = 0;
    logic [2:0]  d_req_size = 0;
    logic [3:0]  d_req_len = 0, d_req_strobe = 0;
    logic        c_resp_ready = 0, c_resp_last = 0;
    logic [31:0] c_resp_data = 0;

    int checks = 0, errors = 0;
    bit chk_on = 0;
    logic [146:0] act [2];
    logic [31:0] words [4] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
    logic [31:0] a0, a1;

    always #5 clk = ~clk;

    // u[0]: ROUND_ROBIN=1, u[1]: ROUND_ROBIN=0
    for (genvar g = 0; g < 2; g++) begin : u
        logic        c_req_valid, c_req_is_write, c_uncached, proto_err;
        logic        i_resp_ready, i_resp_last, d_resp_ready, d_resp_last;
        logic [31:0] c_req_addr, c_req_data, i_resp_data, d_resp_data;
        logic [2:0]  c_req_size;
        logic [3:0]  c_req_len, c_req_strobe;
        cbus_arbiter #(.ROUND_ROBIN(g == 0 ? 1 : 0), .LEN_W(4)) dut (
            .clk(clk), .resetn(resetn),
            .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_len(i_req_len),
            .i_resp_ready(i_resp_ready), .i_resp_last(i_resp_last), .i_resp_data(i_resp_data),
            .d_req_valid(d_req_valid), .d_req_is_write(d_req_is_write), .d_req_addr(d_req_addr),
            .d_req_size(d_req_size), .d_req_len(d_req_len), .d_req_strobe(d_req_strobe),
            .d_req_data(d_req_data), .d_uncached(d_uncached),
            .d_resp_ready(d_resp_ready), .d_resp_last(d_resp_last), .d_resp_data(d_resp_data),
            .c_req_valid(c_req_valid), .c_req_is_write(c_req_is_write), .c_req_addr(c_req_addr),
            .c_req_size(c_req_size), .c_req_len(c_req_len), .c_req_strobe(c_req_strobe),
            .c_req_data(c_req_data), .c_uncached(c_uncached),
            .c_resp_ready(c_resp_ready), .c_resp_last(c_resp_last), .c_resp_data(c_resp_data),
            .proto_err(proto_err)
        );
        assign act[g] = {c_req_valid, c_req_is_write, c_req_addr, c_req_size, c_req_len,
                         c_req_strobe, c_req_data, c_uncached, i_resp_ready, i_resp_last,
                         i_resp_data, d_resp_ready, d_resp_last, d_resp_data, proto_err};
    end

    // Model: owner 0=none 1=I 2=D, beats seen in the current burst, sticky error
    int own [2] = '{0, 0};
    int lastg [2] = '{1, 1};
    int cnt [2] = '{0, 0};
    bit err [2] = '{0, 0};
    int mlen;

    always @(posedge clk or negedge resetn) begin
        for (int k = 0; k < 2; k++) begin
            if (!resetn) begin
                own[k] = 0; lastg[k] = 1; cnt[k] = 0; err[k] = 0;
            end else if (own[k] == 0) begin
                if (d_req_valid && i_req_valid) own[k] = (k == 0) ? 3 - lastg[k] : 2;
                else if (d_req_valid) own[k] = 2;
                else if (i_req_valid) own[k] = 1;
                cnt[k] = 0;
            end else if (c_resp_ready) begin
                mlen = (own[k] == 2) ? int'(d_req_len) : int'(i_req_len);
                if (c_resp_last && cnt[k] != mlen) err[k] = 1;
                if (!c_resp_last && cnt[k] == mlen) err[k] = 1;
                cnt[k]++;
                if (c_resp_last) begin
                    lastg[k] = own[k];
                    own[k] = 0;
                end
            end
        end
    end

    function automatic logic [146:0] expect_out(input int k);
        logic gi, gd;
        gi = (own[k] == 1);
        gd = (own[k] == 2);
        return {gi | gd, gd & d_req_is_write,
                gd ? d_req_addr : (gi ? i_req_addr : 32'h0),
                gd ? d_req_size : (gi ? 3'b010 : 3'b000),
                gd ? d_req_len : (gi ? i_req_len : 4'h0),
                gd ? d_req_strobe : 4'h0,
                gd ? d_req_data : 32'h0,
                gd & d_uncached,
                gi & c_resp_ready, gi & c_resp_last, gi ? c_resp_data : 32'h0,
                gd & c_resp_ready, gd & c_resp_last, gd ? c_resp_data : 32'h0,
                err[k]};
    endfunction

    always @(negedge clk) begin
        if (chk_on) begin
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (act[k] !== expect_out(k)) begin
                    errors++;
                    $display("FAIL cycle_cmp dut%0d got %h expected %h", k, act[k], expect_out(k));
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 0;
        i_req_valid = 0; d_req_valid = 0; d_req_is_write = 0; d_uncached = 0;
        d_req_strobe = 0; d_req_data = 0; c_resp_ready = 0; c_resp_last = 0; c_resp_data = 0;
        tick(); tick();
        resetn = 1;
        tick();
    endtask

    task automatic wait_grant();
        int n = 0;
        while (!u[0].c_req_valid && n < 20) begin
            tick();
            n++;
        end
        chk("grant_timeout", n < 20, 1);
    endtask

    // Serve one burst of n beats with last on beat index last_at; report granted addresses.
    task automatic serve(input int n, input int last_at, output logic [31:0] g0, output logic [31:0] g1);
        wait_grant();
        g0 = u[0].c_req_addr;
        g1 = u[1].c_req_addr;
        for (int b = 0; b < n; b++) begin
            c_resp_ready = 1;
            c_resp_last = (b == last_at);
            c_resp_data = 32'h1000 + b;
            tick();
        end
        c_resp_ready = 0;
        c_resp_last = 0;
        c_resp_data = 0;
    endtask

    initial begin
        #2 resetn = 0;
        #1 chk_on = 1;
        chk("reset_out0", act[0] == 0, 1);
        chk("reset_out1", act[1] == 0, 1);
        tick(); tick();
        resetn = 1;
        tick();

        // D read len=0, one-cycle arbitration latency
        d_req_valid = 1; d_req_addr = 32'h1fc0_0000; d_req_size = 3'b010; d_req_len = 0;
        #2 chk("d_rd_latency", u[0].c_req_valid, 0);
        tick();
        chk("d_rd_grant", u[0].c_req_valid, 1);
        chk("d_rd_addr", u[0].c_req_addr, 32'h1fc0_0000);
        c_resp_ready = 1; c_resp_last = 1; c_resp_data = 32'hdead_beef;
        #1;
        chk("d_rd_data", u[0].d_resp_data, 32'hdead_beef);
        chk("d_rd_last", u[0].d_resp_last, 1);
        chk("d_rd_i_quiet", u[0].i_resp_ready, 0);
        tick();
        d_req_valid = 0; c_resp_ready = 0; c_resp_last = 0; c_resp_data = 0;
        #1;
        chk("d_rd_bubble", u[0].c_req_valid, 0);
        chk("d_rd_no_err", u[0].proto_err, 0);
        tick();

        // Both held continuously: RR alternates D,I,D,I; fixed priority always D
        do_reset();
        d_req_addr = 32'h8000_0000; d_req_len = 1; i_req_addr = 32'h0000_1000; i_req_len = 1;
        d_req_valid = 1; i_req_valid = 1;
        for (int n = 0; n < 4; n++) begin
            serve(2, 1, a0, a1);
            chk("rr_order", a0, (n % 2 == 0) ? 32'h8000_0000 : 32'h0000_1000);
            chk("fixed_order", a1, 32'h8000_0000);
        end
        d_req_valid = 0;
        serve(2, 1, a0, a1);
        chk("fixed_i_when_d_idle", a1, 32'h0000_1000);
        chk("rr_i_when_d_idle", a0, 32'h0000_1000);
        i_req_valid = 0;
        tick();

        // Uncached D write burst of 4 beats
        d_req_is_write = 1; d_uncached = 1; d_req_strobe = 4'hf; d_req_len = 3;
        d_req_addr = 32'hbfc0_0100; d_req_data = words[0]; d_req_valid = 1;
        wait_grant();
        chk("wr_uncached", u[0].c_uncached, 1);
        chk("wr_len", u[0].c_req_len, 3);
        chk("wr_is_write", u[1].c_req_is_write, 1);
        for (int b = 0; b < 4; b++) begin
            d_req_data = words[b];
            c_resp_ready = 1;
            c_resp_last = (b == 3);
            #1;
            chk("wr_data", u[0].c_req_data, words[b]);
            chk("wr_last", u[0].d_resp_last, b == 3);
            tick();
        end
        c_resp_ready = 0; c_resp_last = 0; d_req_valid = 0;
        d_req_is_write = 0; d_uncached = 0; d_req_strobe = 0;
        #1;
        chk("wr_no_err", u[0].proto_err, 0);
        chk("wr_released", u[0].c_req_valid, 0);
        tick();

        // I burst len=7 ending early on beat 5
        i_req_addr = 32'h0000_2000; i_req_len = 7; i_req_valid = 1;
        serve(6, 5, a0, a1);
        i_req_valid = 0;
        #1;
        chk("early_last_err0", u[0].proto_err, 1);
        chk("early_last_err1", u[1].proto_err, 1);
        chk("early_last_idle", u[0].c_req_valid, 0);
        tick(); tick();
        chk("err_sticky", u[0].proto_err, 1);

        // Missing last at beat==len
        do_reset();
        chk("err_cleared", u[0].proto_err, 0);
        d_req_addr = 32'h0000_0040; d_req_len = 1; d_req_is_write = 0; d_req_valid = 1;
        serve(3, 2, a0, a1);
        d_req_valid = 0;
        #1 chk("missing_last_err", u[0].proto_err, 1);
        tick();

        // Reset during I burst beat 2
        do_reset();
        i_req_addr = 32'h0000_3000; i_req_len = 7; i_req_valid = 1;
        wait_grant();
        c_resp_ready = 1; c_resp_last = 0; c_resp_data = 32'h5555_0000;
        tick(); tick();
        chk("mid_burst_fwd", u[0].i_resp_ready, 1);
        #2 resetn = 0;
        #1;
        chk("mid_reset_out0", act[0] == 0, 1);
        chk("mid_reset_out1", act[1] == 0, 1);
        tick();
        c_resp_ready = 0; c_resp_data = 0; i_req_valid = 0;
        resetn = 1;
        tick();
        chk("no_stale_grant0", u[0].c_req_valid, 0);
        chk("no_stale_grant1", u[1].c_req_valid, 0);
        tick();
        chk("still_idle", u[0].c_req_valid, 0);
        chk("reset_err_clear", u[0].proto_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
